// File: rtl/spi_control_fsm_pkg.sv
// Shared types for the SPI slave transaction controller.
// State encoding, R/W polarity and counter sizing.
package spi_control_fsm_pkg;

  typedef enum logic [2:0] {
    IDLE        = 3'd0,
    GET_ADDR    = 3'd1,
    GOT_ADDR    = 3'd2,
    READ_LOAD   = 3'd3,
    READ_SHIFT  = 3'd4,
    WRITE_RECV  = 3'd5,
    WRITE_STORE = 3'd6,
    DONE        = 3'd7
  } state_t;

  localparam logic RW_READ = 1'b1;

  function automatic int cntWidth(int addrBits, int dataBits);
    return $clog2(addrBits + dataBits + 1);
  endfunction

endpackage

// File: rtl/spi_control_fsm_bit_counter.sv
// Edge counter shared by address and data phases.
// hit flags that the next increment reaches term.
module spi_control_fsm_bit_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] term,
  output logic         hit
);

  logic [W-1:0] count;
  logic [W-1:0] countNext;

  assign countNext = count + W'(1);
  assign hit       = (countNext == term);

  // count register: clear wins over increment
  always_ff @(posedge clk) begin
    if (reset || clr) begin
      count <= '0;
    end else if (en) begin
      count <= countNext;
    end
  end

endmodule

// File: rtl/spi_control_fsm.sv
// SPI slave transaction controller.
// Moore strobes for address latch, SR load, DM write, MISO enable.
module spi_control_fsm
  import spi_control_fsm_pkg::*;
#(
  parameter int ADDR_BITS = 7,
  parameter int DATA_BITS = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic cs_n,
  input  logic sclk_pos,
  input  logic sclk_neg,
  input  logic rw_bit,
  output logic addr_we,
  output logic sr_we,
  output logic dm_we,
  output logic miso_buff
);

  localparam int CW = cntWidth(ADDR_BITS, DATA_BITS);

  state_t        state;
  state_t        nextState;
  logic          cntClr;
  logic          cntEn;
  logic          cntHit;
  logic [CW-1:0] cntTerm;

  // address phase also counts the R/W bit
  assign cntTerm = (state == GET_ADDR) ? CW'(ADDR_BITS + 1)
                                       : CW'(DATA_BITS);

  spi_control_fsm_bit_counter #(
    .W(CW)
  ) uCnt (
    .clk  (clk),
    .reset(reset),
    .clr  (cntClr),
    .en   (cntEn),
    .term (cntTerm),
    .hit  (cntHit)
  );

  // state register
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  // next state, counter control and Moore outputs
  always_comb begin
    nextState = state;
    cntClr    = 1'b0;
    cntEn     = 1'b0;
    addr_we   = 1'b0;
    sr_we     = 1'b0;
    dm_we     = 1'b0;
    miso_buff = 1'b0;
    unique case (state)
      IDLE: begin
        cntClr = 1'b1;
        if (!cs_n) nextState = GET_ADDR;
      end
      GET_ADDR: begin
        cntEn = sclk_pos;
        if (sclk_pos && cntHit) nextState = GOT_ADDR;
      end
      GOT_ADDR: begin
        addr_we   = 1'b1;
        cntClr    = 1'b1;
        nextState = (rw_bit == RW_READ) ? READ_LOAD
                                        : WRITE_RECV;
      end
      READ_LOAD: begin
        sr_we     = 1'b1;
        nextState = READ_SHIFT;
      end
      READ_SHIFT: begin
        miso_buff = 1'b1;
        cntEn     = sclk_neg;
        if (sclk_neg && cntHit) nextState = DONE;
      end
      WRITE_RECV: begin
        cntEn = sclk_pos;
        if (sclk_pos && cntHit) nextState = WRITE_STORE;
      end
      WRITE_STORE: begin
        dm_we     = 1'b1;
        nextState = DONE;
      end
      DONE: begin
        nextState = DONE;
      end
      default: nextState = IDLE;
    endcase
    // chip select release overrides any edge-driven move
    if (cs_n && state != IDLE) begin
      nextState = IDLE;
      cntClr    = 1'b1;
      cntEn     = 1'b0;
    end
  end

endmodule

// File: tb/tb_spi_control_fsm.sv
// Directed bench for the SPI slave transaction controller.
// Scenario tasks with inline expected values.
module tb_spi_control_fsm;

  logic clk = 1'b0;
  logic reset;
  logic cs_n;
  logic sclk_pos;
  logic sclk_neg;
  logic rw_bit;
  logic addr_we;
  logic sr_we;
  logic dm_we;
  logic miso_buff;
  logic [3:0] outs;

  int errors = 0;
  int checks = 0;
  int nAddr = 0;
  int nSr = 0;
  int nDm = 0;
  int nMiso = 0;
  int nMisoNeg = 0;
  int nOverlap = 0;

  spi_control_fsm dut (
    .clk      (clk),
    .reset    (reset),
    .cs_n     (cs_n),
    .sclk_pos (sclk_pos),
    .sclk_neg (sclk_neg),
    .rw_bit   (rw_bit),
    .addr_we  (addr_we),
    .sr_we    (sr_we),
    .dm_we    (dm_we),
    .miso_buff(miso_buff)
  );

  assign outs = {addr_we, sr_we, dm_we, miso_buff};

  always #5 clk = ~clk;

  // strobe activity tally, sampled mid-cycle
  always @(negedge clk) begin
    if (addr_we) nAddr++;
    if (sr_we) nSr++;
    if (dm_we) nDm++;
    if (miso_buff) nMiso++;
    if (miso_buff && sclk_neg) nMisoNeg++;
    if ((int'(addr_we) + int'(sr_we) + int'(dm_we)) > 1) nOverlap++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulsePos();
    sclk_pos = 1'b1;
    tick();
    sclk_pos = 1'b0;
    tick();
  endtask

  // first ADDR_BITS bits, MSB first; rw_bit mirrors the SR LSB
  task automatic shiftAddr(input logic [6:0] addr);
    for (int i = 6; i >= 0; i--) begin
      sclk_pos = 1'b1;
      tick();
      rw_bit   = addr[i];
      sclk_pos = 1'b0;
      tick();
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; cs_n = 1'b0; sclk_pos = 1'b1; sclk_neg = 1'b1; rw_bit = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if (outs !== 4'b0000) begin
        errors++; $display("FAIL reset_outs[%0d]: got %b want 0000", i, outs);
      end
    end
    sclk_pos = 1'b0; sclk_neg = 1'b0; reset = 1'b0; rw_bit = 1'b0;
    tick();
    shiftAddr(7'h15);
    checks++;
    if (outs !== 4'b0000) begin
      errors++; $display("FAIL reset_addr7: got %b want 0000", outs);
    end
    sclk_pos = 1'b1;
    tick();
    rw_bit = 1'b0;
    checks++;
    if (outs !== 4'b1000) begin
      errors++; $display("FAIL reset_gotaddr: got %b want 1000", outs);
    end
    sclk_pos = 1'b0;
    tick();
    cs_n = 1'b1;
    tick();
    checks++;
    if (outs !== 4'b0000) begin
      errors++; $display("FAIL reset_abort: got %b want 0000", outs);
    end
  endtask

  task automatic test_write();
    int bA = nAddr; int bS = nSr; int bD = nDm; int bM = nMiso;
    cs_n = 1'b0;
    tick();
    shiftAddr(7'h15);
    sclk_pos = 1'b1;
    tick();
    rw_bit = 1'b0;
    checks++;
    if (outs !== 4'b1000) begin
      errors++; $display("FAIL wr_addr_we: got %b want 1000", outs);
    end
    sclk_pos = 1'b0;
    tick();
    checks++;
    if (outs !== 4'b0000) begin
      errors++; $display("FAIL wr_recv: got %b want 0000", outs);
    end
    repeat (7) pulsePos();
    checks++;
    if (outs !== 4'b0000) begin
      errors++; $display("FAIL wr_data7: got %b want 0000", outs);
    end
    sclk_pos = 1'b1;
    tick();
    checks++;
    if (outs !== 4'b0010) begin
      errors++; $display("FAIL wr_dm_we: got %b want 0010", outs);
    end
    sclk_pos = 1'b0;
    tick();
    checks++;
    if (outs !== 4'b0000) begin
      errors++; $display("FAIL wr_done: got %b want 0000", outs);
    end
    cs_n = 1'b1;
    tick();
    checks++;
    if ({nAddr - bA, nSr - bS, nDm - bD, nMiso - bM} !== {32'd1, 32'd0, 32'd1, 32'd0}) begin
      errors++;
      $display("FAIL wr_counts: got a=%0d s=%0d d=%0d m=%0d want 1 0 1 0",
               nAddr - bA, nSr - bS, nDm - bD, nMiso - bM);
    end
  endtask

  task automatic test_read();
    int bA = nAddr; int bS = nSr; int bD = nDm; int bN = nMisoNeg;
    cs_n = 1'b0;
    tick();
    shiftAddr(7'h2A);
    sclk_pos = 1'b1;
    tick();
    rw_bit = 1'b1;
    checks++;
    if (outs !== 4'b1000) begin
      errors++; $display("FAIL rd_addr_we: got %b want 1000", outs);
    end
    sclk_pos = 1'b0;
    tick();
    checks++;
    if (outs !== 4'b0100) begin
      errors++; $display("FAIL rd_sr_we: got %b want 0100", outs);
    end
    tick();
    checks++;
    if (outs !== 4'b0001) begin
      errors++; $display("FAIL rd_miso_on: got %b want 0001", outs);
    end
    for (int i = 0; i < 7; i++) begin
      sclk_neg = 1'b1;
      sclk_pos = (i == 0);
      tick();
      sclk_neg = 1'b0;
      sclk_pos = 1'b0;
      tick();
    end
    pulsePos();
    checks++;
    if (outs !== 4'b0001) begin
      errors++; $display("FAIL rd_neg7: got %b want 0001", outs);
    end
    sclk_neg = 1'b1;
    tick();
    checks++;
    if (outs !== 4'b0000) begin
      errors++; $display("FAIL rd_done: got %b want 0000", outs);
    end
    sclk_neg = 1'b0;
    tick();
    sclk_neg = 1'b1;
    tick();
    sclk_neg = 1'b0;
    tick();
    checks++;
    if (outs !== 4'b0000) begin
      errors++; $display("FAIL rd_done_edge: got %b want 0000", outs);
    end
    cs_n = 1'b1;
    tick();
    checks++;
    if ({nAddr - bA, nSr - bS, nDm - bD, nMisoNeg - bN} !== {32'd1, 32'd1, 32'd0, 32'd8}) begin
      errors++;
      $display("FAIL rd_counts: got a=%0d s=%0d d=%0d neg=%0d want 1 1 0 8",
               nAddr - bA, nSr - bS, nDm - bD, nMisoNeg - bN);
    end
  endtask

  task automatic test_abort();
    int bD = nDm;
    cs_n = 1'b0;
    tick();
    shiftAddr(7'h15);
    sclk_pos = 1'b1;
    tick();
    rw_bit = 1'b0;
    sclk_pos = 1'b0;
    tick();
    repeat (5) pulsePos();
    cs_n = 1'b1;
    tick();
    checks++;
    if (outs !== 4'b0000) begin
      errors++; $display("FAIL ab_idle: got %b want 0000", outs);
    end
    repeat (4) pulsePos();
    // abort coincident with the final data edge
    cs_n = 1'b0;
    tick();
    shiftAddr(7'h15);
    sclk_pos = 1'b1;
    tick();
    rw_bit = 1'b0;
    sclk_pos = 1'b0;
    tick();
    repeat (7) pulsePos();
    cs_n = 1'b1;
    sclk_pos = 1'b1;
    tick();
    sclk_pos = 1'b0;
    checks++;
    if (outs !== 4'b0000) begin
      errors++; $display("FAIL ab_last_edge: got %b want 0000", outs);
    end
    tick();
    checks++;
    if (nDm - bD !== 0) begin
      errors++; $display("FAIL ab_no_dm: got %0d want 0", nDm - bD);
    end
    // abort in address phase restarts the bit count
    cs_n = 1'b0;
    tick();
    repeat (3) pulsePos();
    cs_n = 1'b1;
    tick();
    cs_n = 1'b0;
    tick();
    shiftAddr(7'h15);
    checks++;
    if (outs !== 4'b0000) begin
      errors++; $display("FAIL ab_addr7: got %b want 0000", outs);
    end
    sclk_pos = 1'b1;
    tick();
    rw_bit = 1'b0;
    checks++;
    if (outs !== 4'b1000) begin
      errors++; $display("FAIL ab_addr8: got %b want 1000", outs);
    end
    sclk_pos = 1'b0;
    tick();
    cs_n = 1'b1;
    tick();
  endtask

  task automatic test_reset_mid();
    cs_n = 1'b0;
    tick();
    shiftAddr(7'h2A);
    sclk_pos = 1'b1;
    tick();
    rw_bit = 1'b1;
    sclk_pos = 1'b0;
    tick();
    tick();
    for (int i = 0; i < 3; i++) begin
      sclk_neg = 1'b1;
      tick();
      sclk_neg = 1'b0;
      tick();
    end
    checks++;
    if (outs !== 4'b0001) begin
      errors++; $display("FAIL rm_shift: got %b want 0001", outs);
    end
    reset = 1'b1;
    tick();
    checks++;
    if (outs !== 4'b0000) begin
      errors++; $display("FAIL rm_reset: got %b want 0000", outs);
    end
    reset = 1'b0;
    tick();
    shiftAddr(7'h15);
    checks++;
    if (outs !== 4'b0000) begin
      errors++; $display("FAIL rm_addr7: got %b want 0000", outs);
    end
    sclk_pos = 1'b1;
    tick();
    rw_bit = 1'b0;
    checks++;
    if (outs !== 4'b1000) begin
      errors++; $display("FAIL rm_addr8: got %b want 1000", outs);
    end
    sclk_pos = 1'b0;
    tick();
    cs_n = 1'b1;
    tick();
  endtask

  task automatic test_ignored();
    int bA = nAddr; int bD = nDm;
    cs_n = 1'b0;
    tick();
    shiftAddr(7'h15);
    sclk_pos = 1'b1;
    tick();
    rw_bit = 1'b0;
    checks++;
    if (outs !== 4'b1000) begin
      errors++; $display("FAIL ig_addr_we: got %b want 1000", outs);
    end
    tick();
    sclk_pos = 1'b0;
    checks++;
    if (outs !== 4'b0000) begin
      errors++; $display("FAIL ig_after_got: got %b want 0000", outs);
    end
    tick();
    repeat (7) pulsePos();
    checks++;
    if (outs !== 4'b0000) begin
      errors++; $display("FAIL ig_data7: got %b want 0000", outs);
    end
    sclk_pos = 1'b1;
    tick();
    checks++;
    if (outs !== 4'b0010) begin
      errors++; $display("FAIL ig_dm_we: got %b want 0010", outs);
    end
    sclk_pos = 1'b0;
    tick();
    repeat (3) pulsePos();
    checks++;
    if (outs !== 4'b0000) begin
      errors++; $display("FAIL ig_done: got %b want 0000", outs);
    end
    checks++;
    if ({nAddr - bA, nDm - bD} !== {32'd1, 32'd1}) begin
      errors++;
      $display("FAIL ig_counts: got a=%0d d=%0d want 1 1", nAddr - bA, nDm - bD);
    end
    cs_n = 1'b1;
    tick();
  endtask

  initial begin
    reset = 1'b1; cs_n = 1'b1; sclk_pos = 1'b0; sclk_neg = 1'b0; rw_bit = 1'b0;
    test_reset();
    test_write();
    test_read();
    test_abort();
    test_reset_mid();
    test_ignored();
    checks++;
    if (nOverlap !== 0) begin
      errors++; $display("FAIL strobe_overlap: got %0d want 0", nOverlap);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
